// File: rtl/program_loader.sv
// Boot loader: assembles 18-bit instruction words from a byte stream and writes them to program memory.
// It checks the frame's XOR checksum and holds the CPU until a valid image has been loaded.
module program_loader #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 18
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [7:0]        i_rxData,
  input  logic              i_rxValid,
  output logic              o_rxReady,
  input  logic              i_restart,
  output logic [ADDR_W-1:0] o_wAddr,
  output logic [WORD_W-1:0] o_wData,
  output logic              o_wEn,
  output logic              o_cpuHold,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [3:0] {
    CNT_HI, CNT_LO, B0, B1, B2, WRITE, CHK, DONE, ERROR
  } state_t;

  state_t              state, next_state;
  logic [15:0]         count;
  logic [ADDR_W-1:0]   index;
  logic [1:0]          asm_hi;
  logic [7:0]          asm_mid;
  logic [7:0]          csum;
  logic [ADDR_W-1:0]   w_addr;
  logic [WORD_W-1:0]   w_data;
  logic                w_en;
  logic                rx_ready;
  logic                take;
  logic                restart_now;
  logic [31:0]         idx_next;

  assign take        = i_rxValid && rx_ready;
  assign restart_now = i_restart && (state == DONE || state == ERROR);
  assign idx_next    = 32'(index) + 32'd1;

  // The wire protocol numbers bit 0 as the MSB; here bit 7 is that MSB.
  // The "b0[0:5] must be zero" rule therefore tests bits [7:2].
  always_comb begin
    next_state = state;
    case (state)
      CNT_HI: if (take) next_state = CNT_LO;
      CNT_LO: if (take) next_state = ({count[15:8], i_rxData} != 16'd0) ? B0 : CHK;
      B0:     if (take) next_state = (i_rxData[7:2] != 6'd0) ? ERROR : B1;
      B1:     if (take) next_state = B2;
      B2:     if (take) next_state = WRITE;
      WRITE:  next_state = (idx_next == 32'(count)) ? CHK : B0;
      CHK:    if (take) next_state = (i_rxData == csum) ? DONE : ERROR;
      DONE:   if (i_restart) next_state = CNT_HI;
      ERROR:  if (i_restart) next_state = CNT_HI;
      default: next_state = CNT_HI;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= CNT_HI;
    end else begin
      state <= next_state;
    end
  end

  // Ready is registered from the next state, so it stays low through reset and has no path from valid.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_ready <= 1'b0;
    end else begin
      rx_ready <= (next_state == CNT_HI) || (next_state == CNT_LO) || (next_state == B0) ||
                  (next_state == B1) || (next_state == B2) || (next_state == CHK);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count   <= '0;
      index   <= '0;
      asm_hi  <= '0;
      asm_mid <= '0;
      csum    <= '0;
      w_addr  <= '0;
      w_data  <= '0;
      w_en    <= 1'b0;
    end else begin
      w_en <= 1'b0;
      case (state)
        CNT_HI: if (take) begin
          count[15:8] <= i_rxData;
          csum        <= csum ^ i_rxData;
        end
        CNT_LO: if (take) begin
          count[7:0] <= i_rxData;
          csum       <= csum ^ i_rxData;
        end
        B0: if (take) begin
          asm_hi <= i_rxData[1:0];
          csum   <= csum ^ i_rxData;
        end
        B1: if (take) begin
          asm_mid <= i_rxData;
          csum    <= csum ^ i_rxData;
        end
        B2: if (take) begin
          w_data <= {asm_hi, asm_mid, i_rxData};
          w_addr <= index;
          w_en   <= 1'b1;
          csum   <= csum ^ i_rxData;
        end
        WRITE: index <= index + 1'b1;
        default: begin
          if (restart_now) begin
            count   <= '0;
            index   <= '0;
            asm_hi  <= '0;
            asm_mid <= '0;
            csum    <= '0;
          end
        end
      endcase
    end
  end

  assign o_rxReady = rx_ready;
  assign o_wAddr   = w_addr;
  assign o_wData   = w_data;
  assign o_wEn     = w_en;
  assign o_cpuHold = (state != DONE);
  assign o_done    = (state == DONE);
  assign o_error   = (state == ERROR);

endmodule
